// File: rtl/cmd_uart_bridge.sv
// cmd_uart_bridge: host-side 8N1 UART endpoint of the command/response link.
// Pairs received bytes into 16-bit commands (high byte first) and serializes
// 8-bit responses back to the host. RX and TX run independently (full duplex).
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   RX           serial input from host (asynchronous, idles high)
//   TX           serial output to host (idles high)
//   cmd          assembled command, {first byte, second byte}
//   cmd_rdy      cmd valid; set on low-byte receipt, cleared by clr_cmd_rdy
//   clr_cmd_rdy  pulse from the core that knocks down cmd_rdy
//   resp         response byte, captured when send_resp is accepted
//   send_resp    request to transmit resp (ignored while transmitting)
//   resp_sent    one-cycle pulse once the response stop bit has completed
module cmd_uart_bridge #(
  parameter int unsigned BAUD_DIV = 868
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent
);

  localparam logic [11:0] LP_FULL = 12'(BAUD_DIV);
  localparam logic [11:0] LP_HALF = 12'(BAUD_DIV / 2);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

  // ---------------- RX path ----------------
  logic        r_rx_meta;
  logic        r_rx_s;
  rx_state_t   r_rx_state;
  rx_state_t   w_rx_next;
  logic [11:0] r_rx_cnt;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_shift;
  logic        r_byte_sel;
  logic [15:0] r_cmd;
  logic        r_cmd_rdy;
  logic        w_rx_tick;
  logic        w_rx_shift_en;
  logic        w_rx_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= RX;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rx_state <= RX_IDLE;
    else        r_rx_state <= w_rx_next;
  end

  // Counter is loaded with N and the sample happens on the edge where it
  // reads 1, i.e. exactly N cycles after the load.
  always_comb begin
    w_rx_next     = r_rx_state;
    w_rx_shift_en = 1'b0;
    w_rx_accept   = 1'b0;
    w_rx_tick     = (r_rx_cnt == 12'd1);
    case (r_rx_state)
      RX_IDLE:  if (!r_rx_s) w_rx_next = RX_START;
      RX_START: if (w_rx_tick) w_rx_next = r_rx_s ? RX_IDLE : RX_DATA;
      RX_DATA: begin
        if (w_rx_tick) begin
          w_rx_shift_en = 1'b1;
          if (r_rx_bit == 3'd7) w_rx_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (w_rx_tick) begin
          w_rx_accept = r_rx_s;
          w_rx_next   = RX_IDLE;
        end
      end
      default: w_rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_byte_sel <= 1'b0;
      r_cmd      <= '0;
      r_cmd_rdy  <= 1'b0;
    end else begin
      if (r_rx_state == RX_IDLE) begin
        r_rx_cnt <= LP_HALF;
        r_rx_bit <= '0;
      end else if (w_rx_tick) begin
        r_rx_cnt <= LP_FULL;
      end else begin
        r_rx_cnt <= r_rx_cnt - 12'd1;
      end

      if (w_rx_shift_en) begin
        r_rx_shift <= {r_rx_s, r_rx_shift[7:1]};
        r_rx_bit   <= r_rx_bit + 3'd1;
      end

      // A low-byte set takes priority over a coincident clear.
      if (w_rx_accept) begin
        if (!r_byte_sel) begin
          r_cmd[15:8] <= r_rx_shift;
          r_cmd_rdy   <= 1'b0;
          r_byte_sel  <= 1'b1;
        end else begin
          r_cmd[7:0]  <= r_rx_shift;
          r_cmd_rdy   <= 1'b1;
          r_byte_sel  <= 1'b0;
        end
      end else if (clr_cmd_rdy) begin
        r_cmd_rdy <= 1'b0;
      end
    end
  end

  assign cmd     = r_cmd;
  assign cmd_rdy = r_cmd_rdy;

  // ---------------- TX path ----------------
  tx_state_t   r_tx_state;
  tx_state_t   w_tx_next;
  logic [9:0]  r_tx_shift;
  logic [11:0] r_tx_cnt;
  logic [3:0]  r_tx_bit;
  logic        r_resp_sent;
  logic        w_tx_load;
  logic        w_tx_tick;
  logic        w_tx_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_tx_state <= TX_IDLE;
    else        r_tx_state <= w_tx_next;
  end

  always_comb begin
    w_tx_next = r_tx_state;
    w_tx_load = 1'b0;
    w_tx_done = 1'b0;
    w_tx_tick = (r_tx_cnt == 12'd1);
    case (r_tx_state)
      TX_IDLE: begin
        if (send_resp) begin
          w_tx_load = 1'b1;
          w_tx_next = TX_BUSY;
        end
      end
      TX_BUSY: begin
        if (w_tx_tick && (r_tx_bit == 4'd9)) begin
          w_tx_done = 1'b1;
          w_tx_next = TX_IDLE;
        end
      end
      default: w_tx_next = TX_IDLE;
    endcase
  end

  // Shifter idles all ones so TX reads high whenever nothing is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_shift  <= '1;
      r_tx_cnt    <= '0;
      r_tx_bit    <= '0;
      r_resp_sent <= 1'b0;
    end else begin
      r_resp_sent <= w_tx_done;
      if (w_tx_load) begin
        r_tx_shift <= {1'b1, resp, 1'b0};
        r_tx_cnt   <= LP_FULL;
        r_tx_bit   <= '0;
      end else if (r_tx_state == TX_BUSY) begin
        if (w_tx_tick) begin
          r_tx_shift <= {1'b1, r_tx_shift[9:1]};
          r_tx_cnt   <= LP_FULL;
          r_tx_bit   <= r_tx_bit + 4'd1;
        end else begin
          r_tx_cnt <= r_tx_cnt - 12'd1;
        end
      end
    end
  end

  assign TX        = r_tx_shift[0];
  assign resp_sent = r_resp_sent;

endmodule

// File: tb/tb_cmd_uart_bridge.sv
// tb_cmd_uart_bridge: directed bench for cmd_uart_bridge with BAUD_DIV=16.
// Expected commands and TX bit values are queued when stimulus is driven and
// popped when the DUT produces them.
module tb_cmd_uart_bridge;

  localparam int unsigned BD = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        r_rx = 1'b1;
  logic        r_loop = 1'b0;
  logic        clr_cmd_rdy = 1'b0;
  logic        send_resp = 1'b0;
  logic [7:0]  resp = '0;
  logic        TX;
  logic        cmd_rdy;
  logic        resp_sent;
  logic [15:0] cmd;
  logic        w_rx;

  int n_checks = 0;
  int n_errors = 0;
  int n_sent   = 0;
  int exp_sent = 0;

  logic [15:0] exp_cmd_q[$];
  logic        exp_tx_q[$];
  logic        prev_rdy = 1'b0;
  logic [15:0] mon_exp;

  assign w_rx = r_loop ? TX : r_rx;

  always #5 clk = ~clk;

  cmd_uart_bridge #(.BAUD_DIV(BD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RX         (w_rx),
    .TX         (TX),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .resp       (resp),
    .send_resp  (send_resp),
    .resp_sent  (resp_sent)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Command scoreboard: every rising cmd_rdy must match the oldest queued command.
  always @(negedge clk) begin
    if (cmd_rdy === 1'b1 && prev_rdy !== 1'b1) begin
      n_checks++;
      assert (exp_cmd_q.size() != 0) else begin
        n_errors++;
        $error("FAIL cmd_unexpected: observed %h expected none", cmd);
      end
      if (exp_cmd_q.size() != 0) begin
        mon_exp = exp_cmd_q.pop_front();
        chk("cmd_value", cmd, mon_exp);
      end
    end
    prev_rdy = cmd_rdy;
    if (resp_sent === 1'b1) n_sent++;
  end

  // Host-side 8N1 frame; optionally checks cmd_rdy around the stop sample.
  task automatic send_byte(input logic [7:0] b, input logic stop_ok, input logic chk_rdy);
    @(negedge clk) r_rx = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      r_rx = b[i];
      repeat (BD) @(negedge clk);
    end
    r_rx = stop_ok;
    repeat (BD / 2) @(negedge clk);
    if (chk_rdy) chk("cmd_rdy_before_stop_sample", {15'b0, cmd_rdy}, 16'h0000);
    repeat (BD / 2) @(negedge clk);
    if (chk_rdy) chk("cmd_rdy_after_stop_sample", {15'b0, cmd_rdy}, 16'h0001);
    r_rx = 1'b1;
    if (!stop_ok) repeat (2 * BD) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [15:0] w);
    exp_cmd_q.push_back(w);
    send_byte(w[15:8], 1'b1, 1'b0);
    send_byte(w[7:0], 1'b1, 1'b0);
  endtask

  // Request a response and check every bit mid-period plus the resp_sent pulse.
  task automatic tx_send(input logic [7:0] b, input logic dup);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) exp_tx_q.push_back(fr[i]);
    exp_sent++;
    @(negedge clk);
    resp = b;
    send_resp = 1'b1;
    @(negedge clk) send_resp = 1'b0;
    repeat (BD / 2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk("tx_bit", {15'b0, TX}, {15'b0, exp_tx_q.pop_front()});
      if (i < 9) begin
        if (dup && i == 4) begin
          send_resp = 1'b1;
          resp = 8'h00;
          @(negedge clk) send_resp = 1'b0;
          repeat (BD - 1) @(negedge clk);
        end else begin
          repeat (BD) @(negedge clk);
        end
      end
    end
    repeat (BD / 2) @(negedge clk);
    chk("resp_sent_pulse", {15'b0, resp_sent}, 16'h0001);
    chk("tx_high_at_resp_sent", {15'b0, TX}, 16'h0001);
    @(negedge clk);
    chk("resp_sent_one_cycle", {15'b0, resp_sent}, 16'h0000);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_tx", {15'b0, TX}, 16'h0001);
    chk("reset_cmd", cmd, 16'h0000);
    chk("reset_cmd_rdy", {15'b0, cmd_rdy}, 16'h0000);
    chk("reset_resp_sent", {15'b0, resp_sent}, 16'h0000);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Two-byte command, then clear
    exp_cmd_q.push_back(16'hA53C);
    send_byte(8'hA5, 1'b1, 1'b0);
    send_byte(8'h3C, 1'b1, 1'b1);
    @(negedge clk) clr_cmd_rdy = 1'b1;
    @(negedge clk) clr_cmd_rdy = 1'b0;
    chk("cmd_rdy_cleared", {15'b0, cmd_rdy}, 16'h0000);
    chk("cmd_held_after_clear", cmd, 16'hA53C);

    // Framing error discards the byte without advancing the pairing
    send_byte(8'h12, 1'b0, 1'b0);
    send_cmd(16'h3456);
    repeat (4) @(negedge clk);
    chk("cmd_after_framing", cmd, 16'h3456);

    // Short low glitch: no byte accepted, pairing still expects a high byte
    @(negedge clk) r_rx = 1'b0;
    repeat (4) @(negedge clk);
    r_rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_cmd_rdy_kept", {15'b0, cmd_rdy}, 16'h0001);
    chk("glitch_cmd_kept", cmd, 16'h3456);
    send_cmd(16'h9ABC);

    // Response transmit with an ignored mid-frame request
    tx_send(8'h81, 1'b1);
    repeat (3 * BD) @(negedge clk);
    chk("tx_idle_after_frame", {15'b0, TX}, 16'h0001);

    // Full duplex
    fork
      send_cmd(16'hC0DE);
      tx_send(8'hFF, 1'b0);
    join
    repeat (4) @(negedge clk);

    // Loopback TX -> RX
    r_loop = 1'b1;
    exp_cmd_q.push_back(16'h5AA5);
    tx_send(8'h5A, 1'b0);
    tx_send(8'hA5, 1'b0);
    repeat (BD) @(negedge clk);
    r_loop = 1'b0;
    chk("loopback_cmd", cmd, 16'h5AA5);

    // Reset mid-frame: high byte in, TX and low byte in flight
    send_byte(8'h77, 1'b1, 1'b0);
    @(negedge clk);
    resp = 8'h00;
    send_resp = 1'b1;
    @(negedge clk) send_resp = 1'b0;
    r_rx = 1'b0;
    repeat (20) @(negedge clk);
    chk("tx_low_before_reset", {15'b0, TX}, 16'h0000);
    rst_n = 1'b0;
    #1;
    chk("tx_high_in_reset", {15'b0, TX}, 16'h0001);
    chk("cmd_cleared_in_reset", cmd, 16'h0000);
    chk("cmd_rdy_in_reset", {15'b0, cmd_rdy}, 16'h0000);
    r_rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send_cmd(16'h0102);
    repeat (4) @(negedge clk);
    chk("cmd_after_reset", cmd, 16'h0102);

    // Nothing outstanding, no extra pulses
    repeat (2 * BD) @(negedge clk);
    chk("cmd_queue_drained", 16'(exp_cmd_q.size()), 16'h0000);
    chk("resp_sent_count", 16'(n_sent), 16'(exp_sent));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
